mips_mc_cpu_hs: RTL and testbench
=================================

Name: mips_mc_cpu_hs

Overview:
- Parametrised successor to the team's five-state multi-cycle MIPS core (IF/ID/EXE/MEM/WB).
- Adds a memory wait-state handshake (mem_req/mem_ready), a parametrised reset vector and parametrised I/O and VRAM region tags.
- Adds retire and illegal-instruction status pulses.
- Sits between SoC memory/VGA/PS2 glue and a unified instruction/data memory that may take several cycles to respond.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IO_TAG, 3'b101, addr[31:29] value selecting I/O space (PS2).
- VRAM_TAG, 3'b110, addr[31:29] value selecting video RAM.

Ports:
- cpu_clk  in  1  core clock
- resetn  in  1  reset
- m_addr  out  32  memory address: pc in IF, register C otherwise
- d_f_mem  in  32  read data from memory/IO/VRAM
- d_t_mem  out  32  store data (reg[rt])
- mem_req  out  1  request to main memory, held until mem_ready
- mem_ready  in  1  main memory completes request this cycle
- w_d_mem  out  1  write main memory (sw, normal space)
- wr_vram  out  1  VRAM write strobe
- rd_vram  out  1  VRAM read strobe
- io_rdn  out  1  I/O read, active low
- state  out  3  FSM state: IF=0, ID=1, EXE=2, MEM=3, WB=4
- retired  out  1  one-cycle pulse when an instruction completes
- illegal  out  1  one-cycle pulse on undecoded instruction

Behaviour:
- Reset is resetn, asynchronous, active-low; clock is cpu_clk.
- Reset values:
  - pc=RESET_PC, ir=0, C=0, D=0, regfile $1-$31=0, state=IF.
  - retired=0, illegal=0.
  - mem_req forced 0 while resetn=0.
- A reset mid-instruction abandons the instruction. No write may occur on the reset edge.
- ISA: add sub and or xor sll srl sra jr addi andi ori xori lw sw beq bne lui j jal, with standard MIPS encodings.
  - $0 reads 0; writes to $0 are dropped.
  - All arithmetic is 32-bit wrap-around, with no overflow trap.
- IF:
  - m_addr=pc, mem_req=1.
  - State holds while mem_ready=0.
  - On mem_ready=1: ir<=d_f_mem, pc<=pc+4, go to ID.
- ID:
  - j: pc<={pc[31:28],addr,00}, go to IF.
  - jal: same as j, plus $31<=pc (already pc_of_jal+4).
  - jr: pc<=reg[rs], go to IF.
  - Otherwise C<=pc+(sext(imm)<<2), go to EXE.
  - j, jal and jr each pulse retired on the ID cycle.
- EXE:
  - ALU ops, addi/andi/ori/xori/lui: compute into C, go to WB.
  - lw/sw: C<=reg[rs]+sext(imm), go to MEM.
  - beq/bne: pc<=C if taken, go to IF, pulse retired.
  - Undecoded instruction: pulse illegal, go to IF, treated as a nop, no retired pulse.
- MEM, with m_addr=C and region = C[31:29]:
  - Normal region: mem_req=1; w_d_mem=1 for sw. Hold until mem_ready=1. D captures d_f_mem on the ready cycle.
  - IO_TAG region, lw: io_rdn=0 for exactly one cycle, D<=d_f_mem, no handshake.
  - VRAM_TAG region: rd_vram (lw) or wr_vram (sw) for exactly one cycle, no handshake.
  - sw goes to IF with a retired pulse; lw goes to WB.
- WB:
  - Destination is rt for lw and immediate ops, rd otherwise.
  - Data is D for lw, C otherwise.
  - Go to IF, pulse retired.
- mem_ready is ignored outside handshake cycles. A mem_ready already high on the first request cycle gives zero wait states.
- Timing: IF-to-retire minimum latency is 3 cycles (j), 5 cycles (R-type), 6 cycles (lw, zero wait).

Optional Feature:
- MIPS_MC_SLT_EN
- Defined: decodes slt (func 2A), sltu (2B), slti (op 0A), sltiu (op 0B) and nor (func 27).
  - slt/slti compare signed; sltu/sltiu compare unsigned.
  - Immediates are sign-extended for both signed and unsigned forms.
  - Result is 32'h0/32'h1 (nor: ~(a|b)).
- Undefined: these encodings take the illegal path.

Decomposition:
- Package mips_mc_pkg holds:
  - state encodings S_IF..S_WB
  - opcode and func constants
  - region-tag defaults
- One sub-module is natural: mips_mc_alu, a combinational op-select to 32-bit result, which also hosts the SLT logic under the macro.
- Regfile stays inline.

Test Plan:
- Reset vector: RESET_PC=32'h100, pulse resetn low mid-EXE → state=0, m_addr=32'h100, mem_req=0 during reset, then 1; regfile reads 0.
- Wait states: addi $1,$0,5 with mem_ready delayed 3 cycles in IF → state holds IF for 3 cycles; retired pulses 8 cycles after first request; $1=5.
- Load/store: sw $1,0x40($0) then lw $2,0x40($0) → w_d_mem=1 with m_addr=0x40 and d_t_mem=5; $2=5.
- Regions:
  - lw $3,0($4) with $4=32'hA000_0000, d_f_mem=32'h1C → io_rdn low 1 cycle, mem_req=0, $3=32'h1C.
  - sw to 32'hC000_0010 → wr_vram 1 cycle.
- Control flow:
  - beq $0,$0,-1 → pc returns to the beq address.
  - jal 0x40 at pc=0x10 → $31=0x14, pc=0x100.
  - Illegal opcode 6'h3F → illegal pulse, no register change.
- Macro: with MIPS_MC_SLT_EN, slt with $1=-1, $2=1 → 1; sltu → 0. Without the macro → illegal pulse.

Source files
------------

// File: rtl/mips_mc_pkg.sv
// Shared constants for the multi-cycle MIPS core: FSM encodings, opcode/func
// fields, ALU operation select and default address-region tags.
package mips_mc_pkg;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EXE = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    localparam logic [2:0] IO_TAG_DEF   = 3'b101;
    localparam logic [2:0] VRAM_TAG_DEF = 3'b110;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_SLT, ALU_SLTU
    } alu_op_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/mips_mc_alu.sv
// Combinational ALU: op select to 32-bit result. nor/slt/sltu are only
// decoded when MIPS_MC_SLT_EN is defined.
module mips_mc_alu
    import mips_mc_pkg::*;
(
    input  logic [3:0]  i_op,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [4:0]  i_shamt,
    output logic [31:0] o_result
);

    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SLL:  o_result = i_b << i_shamt;
            ALU_SRL:  o_result = i_b >> i_shamt;
            ALU_SRA:  o_result = $signed(i_b) >>> i_shamt;
            ALU_LUI:  o_result = {i_b[15:0], 16'h0000};
`ifdef MIPS_MC_SLT_EN
            ALU_NOR:  o_result = ~(i_a | i_b);
            ALU_SLT:  o_result = {31'b0, $signed(i_a) < $signed(i_b)};
            ALU_SLTU: o_result = {31'b0, i_a < i_b};
`endif
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_cpu_hs.sv
// Five-state multi-cycle MIPS core with mem_req/mem_ready wait states,
// IO/VRAM region decode and retire/illegal pulses. Optional: MIPS_MC_SLT_EN.
module mips_mc_cpu_hs
    import mips_mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [2:0]  IO_TAG   = IO_TAG_DEF,
    parameter logic [2:0]  VRAM_TAG = VRAM_TAG_DEF
) (
    input  logic        cpu_clk,
    input  logic        resetn,
    output logic [31:0] m_addr,
    input  logic [31:0] d_f_mem,
    output logic [31:0] d_t_mem,
    output logic        mem_req,
    input  logic        mem_ready,
    output logic        w_d_mem,
    output logic        wr_vram,
    output logic        rd_vram,
    output logic        io_rdn,
    output logic [2:0]  state,
    output logic        retired,
    output logic        illegal
);

    logic [31:0] r_pc, r_ir, r_c, r_d;
    logic [2:0]  r_state;
    logic        r_retired, r_illegal;
    logic [31:0] r_regs [0:31];

    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt, w_rd, w_shamt, w_dest;
    logic [31:0] w_rs_val, w_rt_val, w_simm, w_zimm, w_alu_b, w_alu_res;
    alu_op_t     w_alu_op;
    logic        w_alu_ok, w_is_lw, w_is_sw, w_is_br, w_taken;
    logic        w_io, w_vram, w_norm, w_in_mem, w_mem_done;

    assign w_op     = r_ir[31:26];
    assign w_rs     = r_ir[25:21];
    assign w_rt     = r_ir[20:16];
    assign w_rd     = r_ir[15:11];
    assign w_shamt  = r_ir[10:6];
    assign w_funct  = r_ir[5:0];
    assign w_simm   = sext16(r_ir[15:0]);
    assign w_zimm   = {16'h0000, r_ir[15:0]};
    assign w_rs_val = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? '0 : r_regs[w_rt];
    assign w_dest   = (w_op == OP_RTYPE) ? w_rd : w_rt;

    assign w_is_lw  = (w_op == OP_LW);
    assign w_is_sw  = (w_op == OP_SW);
    assign w_is_br  = (w_op == OP_BEQ) || (w_op == OP_BNE);
    assign w_taken  = (w_op == OP_BEQ) ? (w_rs_val == w_rt_val) : (w_rs_val != w_rt_val);

    assign w_io     = (r_c[31:29] == IO_TAG);
    assign w_vram   = (r_c[31:29] == VRAM_TAG);
    assign w_norm   = !w_io && !w_vram;
    // IO and VRAM complete in a single cycle; only normal space handshakes.
    assign w_mem_done = w_norm ? mem_ready : 1'b1;

    always_comb begin
        w_alu_op = ALU_ADD;
        w_alu_b  = w_rt_val;
        w_alu_ok = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                w_alu_ok = 1'b1;
                case (w_funct)
                    F_ADD:   w_alu_op = ALU_ADD;
                    F_SUB:   w_alu_op = ALU_SUB;
                    F_AND:   w_alu_op = ALU_AND;
                    F_OR:    w_alu_op = ALU_OR;
                    F_XOR:   w_alu_op = ALU_XOR;
                    F_SLL:   w_alu_op = ALU_SLL;
                    F_SRL:   w_alu_op = ALU_SRL;
                    F_SRA:   w_alu_op = ALU_SRA;
`ifdef MIPS_MC_SLT_EN
                    F_NOR:   w_alu_op = ALU_NOR;
                    F_SLT:   w_alu_op = ALU_SLT;
                    F_SLTU:  w_alu_op = ALU_SLTU;
`endif
                    default: w_alu_ok = 1'b0;
                endcase
            end
            OP_ADDI:  begin w_alu_op = ALU_ADD;  w_alu_b = w_simm; w_alu_ok = 1'b1; end
            OP_ANDI:  begin w_alu_op = ALU_AND;  w_alu_b = w_zimm; w_alu_ok = 1'b1; end
            OP_ORI:   begin w_alu_op = ALU_OR;   w_alu_b = w_zimm; w_alu_ok = 1'b1; end
            OP_XORI:  begin w_alu_op = ALU_XOR;  w_alu_b = w_zimm; w_alu_ok = 1'b1; end
            OP_LUI:   begin w_alu_op = ALU_LUI;  w_alu_b = w_zimm; w_alu_ok = 1'b1; end
`ifdef MIPS_MC_SLT_EN
            OP_SLTI:  begin w_alu_op = ALU_SLT;  w_alu_b = w_simm; w_alu_ok = 1'b1; end
            OP_SLTIU: begin w_alu_op = ALU_SLTU; w_alu_b = w_simm; w_alu_ok = 1'b1; end
`endif
            default:  w_alu_ok = 1'b0;
        endcase
    end

    mips_mc_alu u_alu (
        .i_op     (w_alu_op),
        .i_a      (w_rs_val),
        .i_b      (w_alu_b),
        .i_shamt  (w_shamt),
        .o_result (w_alu_res)
    );

    always_ff @(posedge cpu_clk or negedge resetn) begin
        if (!resetn) begin
            r_pc      <= RESET_PC;
            r_ir      <= '0;
            r_c       <= '0;
            r_d       <= '0;
            r_state   <= S_IF;
            r_retired <= 1'b0;
            r_illegal <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
        end else begin
            r_retired <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_IF: if (mem_ready) begin
                    r_ir    <= d_f_mem;
                    r_pc    <= r_pc + 32'd4;
                    r_state <= S_ID;
                end
                S_ID: begin
                    if (w_op == OP_J || w_op == OP_JAL) begin
                        r_pc      <= {r_pc[31:28], r_ir[25:0], 2'b00};
                        r_state   <= S_IF;
                        r_retired <= 1'b1;
                        if (w_op == OP_JAL) r_regs[31] <= r_pc;
                    end else if (w_op == OP_RTYPE && w_funct == F_JR) begin
                        r_pc      <= w_rs_val;
                        r_state   <= S_IF;
                        r_retired <= 1'b1;
                    end else begin
                        r_c     <= r_pc + {w_simm[29:0], 2'b00};
                        r_state <= S_EXE;
                    end
                end
                S_EXE: begin
                    if (w_is_lw || w_is_sw) begin
                        r_c     <= w_rs_val + w_simm;
                        r_state <= S_MEM;
                    end else if (w_is_br) begin
                        if (w_taken) r_pc <= r_c;
                        r_state   <= S_IF;
                        r_retired <= 1'b1;
                    end else if (w_alu_ok) begin
                        r_c     <= w_alu_res;
                        r_state <= S_WB;
                    end else begin
                        r_illegal <= 1'b1;
                        r_state   <= S_IF;
                    end
                end
                S_MEM: if (w_mem_done) begin
                    r_d <= d_f_mem;
                    if (w_is_sw) begin
                        r_state   <= S_IF;
                        r_retired <= 1'b1;
                    end else begin
                        r_state <= S_WB;
                    end
                end
                S_WB: begin
                    if (w_dest != 5'd0) r_regs[w_dest] <= w_is_lw ? r_d : r_c;
                    r_state   <= S_IF;
                    r_retired <= 1'b1;
                end
                default: r_state <= S_IF;
            endcase
        end
    end

    assign w_in_mem = resetn && (r_state == S_MEM);
    assign m_addr   = (r_state == S_IF) ? r_pc : r_c;
    assign d_t_mem  = w_rt_val;
    assign mem_req  = resetn && ((r_state == S_IF) || (w_in_mem && w_norm));
    assign w_d_mem  = w_in_mem && w_norm && w_is_sw;
    assign wr_vram  = w_in_mem && w_vram && w_is_sw;
    assign rd_vram  = w_in_mem && w_vram && w_is_lw;
    assign io_rdn   = !(w_in_mem && w_io && w_is_lw);
    assign state    = r_state;
    assign retired  = r_retired;
    assign illegal  = r_illegal;

endmodule

// File: tb/tb_mips_mc_cpu_hs.sv
// Scoreboard bench for mips_mc_cpu_hs: directed programs, a wait-state memory
// responder, and a monitor that pops expected write/IO/illegal events.
module tb_mips_mc_cpu_hs;

    logic        cpu_clk = 1'b0;
    logic        resetn  = 1'b0;
    logic [31:0] m_addr, d_f_mem, d_t_mem;
    logic        mem_req, mem_ready, w_d_mem, wr_vram, rd_vram, io_rdn;
    logic [2:0]  state;
    logic        retired, illegal;

    typedef struct {
        int          kind;   // 0 mem write, 1 vram write, 2 io read, 3 illegal, 4 vram read
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    ev_t         q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] mem [0:1023];
    int          fetch_wait = 0;
    int          mem_wait   = 0;

    mips_mc_cpu_hs #(.RESET_PC(32'h0000_0100)) dut (
        .cpu_clk   (cpu_clk),
        .resetn    (resetn),
        .m_addr    (m_addr),
        .d_f_mem   (d_f_mem),
        .d_t_mem   (d_t_mem),
        .mem_req   (mem_req),
        .mem_ready (mem_ready),
        .w_d_mem   (w_d_mem),
        .wr_vram   (wr_vram),
        .rd_vram   (rd_vram),
        .io_rdn    (io_rdn),
        .state     (state),
        .retired   (retired),
        .illegal   (illegal)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic expect_ev(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d;
        q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [31:0] a, input logic [31:0] d);
        ev_t e;
        if (q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d addr %h data %h, expected none", k, a, d);
        end else begin
            e = q.pop_front();
            check("event_kind", 32'(k), 32'(e.kind));
            check("event_addr", a, e.addr);
            check("event_data", d, e.data);
        end
    endtask

    // Memory responder: one-shot wait counts for the next fetch / data access.
    initial begin
        int cnt;
        int need;
        cnt = 0;
        mem_ready = 1'b0;
        d_f_mem   = '0;
        forever begin
            @(negedge cpu_clk);
            mem_ready = 1'b0;
            d_f_mem   = '0;
            if (mem_req) begin
                need = (state == 3'd3) ? mem_wait : fetch_wait;
                if (cnt < need) begin
                    cnt++;
                end else begin
                    mem_ready = 1'b1;
                    d_f_mem   = mem[m_addr[11:2]];
                    if (w_d_mem) mem[m_addr[11:2]] = d_t_mem;
                    if (state == 3'd3) mem_wait = 0; else fetch_wait = 0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
            if (!io_rdn) d_f_mem = 32'h0000_001C;
            if (rd_vram) d_f_mem = 32'h0000_BEEF;
        end
    end

    // Monitor: every observable side effect must match the next expectation.
    initial begin
        forever begin
            @(negedge cpu_clk);
            #1;
            if (resetn) begin
                if (w_d_mem && mem_ready) observe(0, m_addr, d_t_mem);
                if (wr_vram)              observe(1, m_addr, d_t_mem);
                if (rd_vram)              observe(4, m_addr, d_t_mem);
                if (!io_rdn)              observe(2, m_addr, {31'b0, mem_req});
                if (illegal)              observe(3, 32'h0, 32'h0);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic put(input logic [31:0] a, input logic [31:0] w);
        mem[a[11:2]] = w;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = '0;
    endtask

    task automatic release_reset();
        @(posedge cpu_clk);
        #1 resetn = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && q.size() != 0; i++) @(negedge cpu_clk);
        repeat (20) @(negedge cpu_clk);
        check("queue_drained", 32'(q.size()), 32'd0);
    endtask

    task automatic spin_check(input logic [31:0] a, input int n);
        int found;
        found = 0;
        for (int i = 0; i < 100 && found < n; i++) begin
            @(negedge cpu_clk);
            #2;
            if (state == 3'd0) begin
                check("spin_pc", m_addr, a);
                found++;
            end
        end
        check("spin_samples", 32'(found), 32'(n));
    endtask

    initial begin
        int n_exe, holds, ret_cyc;
        logic found;

        // Phase A: reset values, reset mid-EXE clears the register file.
        clear_mem();
        put(32'h100, 32'hAC05_0050);   // sw   $5,0x50($0)
        put(32'h104, 32'h2005_0007);   // addi $5,$0,7
        put(32'h108, 32'h2006_0009);   // addi $6,$0,9
        put(32'h10C, 32'h1000_FFFF);   // beq  $0,$0,-1
        repeat (3) @(negedge cpu_clk);
        #2;
        check("reset_state",   32'(state),   32'd0);
        check("reset_m_addr",  m_addr,       32'h0000_0100);
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_retired", 32'(retired), 32'd0);
        check("reset_illegal", 32'(illegal), 32'd0);
        expect_ev(0, 32'h50, 32'h0);
        expect_ev(0, 32'h50, 32'h0);
        release_reset();
        @(negedge cpu_clk);
        #2;
        check("mem_req_after_reset", 32'(mem_req), 32'd1);
        n_exe = 0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (state == 3'd2) n_exe++;
            if (n_exe == 3) found = 1'b1;
            else begin @(negedge cpu_clk); #2; end
        end
        check("reached_third_exe", 32'(found), 32'd1);
        resetn = 1'b0;
        #1;
        check("midreset_state",   32'(state),   32'd0);
        check("midreset_m_addr",  m_addr,       32'h0000_0100);
        check("midreset_mem_req", 32'(mem_req), 32'd0);
        repeat (2) @(negedge cpu_clk);
        release_reset();
        wait_drain(300);

        // Phase B: wait states, load/store, regions, ALU, branches, jr.
        @(negedge cpu_clk);
        resetn = 1'b0;
        clear_mem();
        put(32'h100, 32'h2001_0005);   // addi $1,$0,5
        put(32'h104, 32'hAC01_0040);   // sw   $1,0x40($0)
        put(32'h108, 32'h8C02_0040);   // lw   $2,0x40($0)
        put(32'h10C, 32'hAC02_0044);   // sw   $2,0x44($0)
        put(32'h110, 32'h3C04_A000);   // lui  $4,0xA000
        put(32'h114, 32'h8C83_0000);   // lw   $3,0($4)      IO read
        put(32'h118, 32'hAC03_0048);   // sw   $3,0x48($0)
        put(32'h11C, 32'h3C07_C000);   // lui  $7,0xC000
        put(32'h120, 32'hACE1_0010);   // sw   $1,0x10($7)   VRAM write
        put(32'h124, 32'hFC21_FFFF);   // opcode 3F: illegal
        put(32'h128, 32'hAC01_004C);   // sw   $1,0x4C($0)
        put(32'h12C, 32'h2008_FFFD);   // addi $8,$0,-3
        put(32'h130, 32'h0028_4822);   // sub  $9,$1,$8
        put(32'h134, 32'hAC09_0050);   // sw   $9,0x50($0)
        put(32'h138, 32'h0008_5043);   // sra  $10,$8,1
        put(32'h13C, 32'hAC0A_0054);   // sw   $10,0x54($0)
        put(32'h140, 32'h390B_00FF);   // xori $11,$8,0xFF
        put(32'h144, 32'hAC0B_0058);   // sw   $11,0x58($0)
        put(32'h148, 32'h200C_FFFF);   // addi $12,$0,-1
        put(32'h14C, 32'h200D_0001);   // addi $13,$0,1
        put(32'h150, 32'h018D_702A);   // slt  $14,$12,$13
        put(32'h154, 32'h018D_782B);   // sltu $15,$12,$13
        put(32'h158, 32'hAC0E_005C);   // sw   $14,0x5C($0)
        put(32'h15C, 32'hAC0F_0060);   // sw   $15,0x60($0)
        put(32'h160, 32'h1028_0001);   // beq  $1,$8,+1      not taken
        put(32'h164, 32'h2010_0033);   // addi $16,$0,0x33
        put(32'h168, 32'h1428_0001);   // bne  $1,$8,+1      taken
        put(32'h16C, 32'h2010_0077);   // addi $16,$0,0x77   skipped
        put(32'h170, 32'hAC10_0064);   // sw   $16,0x64($0)
        put(32'h174, 32'h2011_0180);   // addi $17,$0,0x180
        put(32'h178, 32'h0220_0008);   // jr   $17
        put(32'h17C, 32'h2012_0001);   // addi $18,$0,1      skipped
        put(32'h180, 32'hAC12_006C);   // sw   $18,0x6C($0)
        put(32'h184, 32'h1000_FFFF);   // beq  $0,$0,-1
        fetch_wait = 3;
        mem_wait   = 2;
        expect_ev(0, 32'h40, 32'h5);
        expect_ev(0, 32'h44, 32'h5);
        expect_ev(2, 32'hA000_0000, 32'h0);
        expect_ev(0, 32'h48, 32'h1C);
        expect_ev(1, 32'hC000_0010, 32'h5);
        expect_ev(3, 32'h0, 32'h0);
        expect_ev(0, 32'h4C, 32'h5);
        expect_ev(0, 32'h50, 32'h8);
        expect_ev(0, 32'h54, 32'hFFFF_FFFE);
        expect_ev(0, 32'h58, 32'hFFFF_FF02);
`ifdef MIPS_MC_SLT_EN
        expect_ev(0, 32'h5C, 32'h1);
        expect_ev(0, 32'h60, 32'h0);
`else
        expect_ev(3, 32'h0, 32'h0);
        expect_ev(3, 32'h0, 32'h0);
        expect_ev(0, 32'h5C, 32'h0);
        expect_ev(0, 32'h60, 32'h0);
`endif
        expect_ev(0, 32'h64, 32'h33);
        expect_ev(0, 32'h6C, 32'h0);
        release_reset();
        holds   = 0;
        ret_cyc = -1;
        for (int i = 0; i < 50 && ret_cyc < 0; i++) begin
            @(negedge cpu_clk);
            #2;
            if (state == 3'd0 && !mem_ready) holds++;
            if (retired) ret_cyc = i;
        end
        check("if_wait_holds", 32'(holds), 32'd3);
        check("retire_cycle_inclusive", 32'(ret_cyc + 1), 32'd8);
        wait_drain(2000);
        spin_check(32'h184, 4);

        // Phase C: jal from 0x10 lands on the reset vector with $31 = 0x14.
        @(negedge cpu_clk);
        resetn = 1'b0;
        clear_mem();
        put(32'h100, 32'h17E0_0002);   // bne  $31,$0,+2 -> 0x10C
        put(32'h104, 32'h0800_0004);   // j    0x10
        put(32'h10C, 32'hAC1F_0068);   // sw   $31,0x68($0)
        put(32'h110, 32'h1000_FFFF);   // beq  $0,$0,-1
        put(32'h010, 32'h0C00_0040);   // jal  0x100
        fetch_wait = 0;
        mem_wait   = 0;
        expect_ev(0, 32'h68, 32'h14);
        release_reset();
        wait_drain(300);
        spin_check(32'h110, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
